// File: rtl/tlc_pkg.sv
// Shared types and helpers for the traffic light controller.
// TLC_FLASH_EN adds the FLASH phase (code 7).
package tlc_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LAMP_W  = 3;

    // Lamp encoding {red,yellow,green}
    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

    typedef enum logic [PHASE_W-1:0] {
        AR_NS = 3'd0,
        NS_G  = 3'd1,
        NS_Y  = 3'd2,
        AR_EW = 3'd3,
        EW_G  = 3'd4,
        EW_Y  = 3'd5,
        PED   = 3'd6
`ifdef TLC_FLASH_EN
        , FLASH = 3'd7
`endif
    } phase_e;

    // Dwell in ticks for each timed phase; untimed codes return 0.
    function automatic logic [CNT_W-1:0] dur_of(
        input phase_e           p,
        input logic [CNT_W-1:0] green,
        input logic [CNT_W-1:0] yellow,
        input logic [CNT_W-1:0] all_red,
        input logic [CNT_W-1:0] ped
    );
        case (p)
            AR_NS, AR_EW: return all_red;
            NS_G, EW_G:   return green;
            NS_Y, EW_Y:   return yellow;
            PED:          return ped;
            default:      return CNT_W'(0);
        endcase
    endfunction

    // Successor in the fixed rotation; walk is inserted after EW yellow.
    function automatic phase_e next_of(input phase_e p, input logic pend);
        case (p)
            AR_NS:   return NS_G;
            NS_G:    return NS_Y;
            NS_Y:    return AR_EW;
            AR_EW:   return EW_G;
            EW_G:    return EW_Y;
            EW_Y:    return pend ? PED : AR_NS;
            default: return AR_NS;
        endcase
    endfunction

endpackage

// File: rtl/tlc_tick_pulse.sv
// Edge detector: turns the intersection timer's toggling output into a
// one-clk tick pulse for traffic_light_ctrl (instantiated by the integrator).
module tlc_tick_pulse (
    input  logic clk,
    input  logic rstb,
    input  logic timer_out,
    output logic tick
);

    logic timer_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            timer_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            timer_q <= timer_out;
            tick    <= timer_out ^ timer_q;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// NS/EW intersection phase sequencer with latched pedestrian walk phase.
// Define TLC_FLASH_EN to add flash_req and the blinking FLASH phase.
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int unsigned GREEN_TICKS   = 8,
    parameter int unsigned YELLOW_TICKS  = 3,
    parameter int unsigned ALL_RED_TICKS = 2,
    parameter int unsigned PED_TICKS     = 5
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              tick,
    input  logic              enable,
    input  logic              ped_req,
`ifdef TLC_FLASH_EN
    input  logic              flash_req,
`endif
    output logic [LAMP_W-1:0] ns_light,
    output logic [LAMP_W-1:0] ew_light,
    output logic              ped_walk,
    output logic              ped_pending,
    output logic [PHASE_W-1:0] phase,
    output logic              phase_start
);

    localparam logic [CNT_W-1:0] G_DUR  = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] Y_DUR  = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] AR_DUR = CNT_W'(ALL_RED_TICKS);
    localparam logic [CNT_W-1:0] P_DUR  = CNT_W'(PED_TICKS);

    phase_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] dur;
    logic             pend_nxt;
    logic             start_nxt;
`ifdef TLC_FLASH_EN
    logic             blink, blink_nxt;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= AR_NS;
            cnt         <= '0;
            ped_pending <= 1'b0;
            phase_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ped_pending <= pend_nxt;
            phase_start <= start_nxt;
        end
    end

`ifdef TLC_FLASH_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            blink <= 1'b0;
        end else begin
            blink <= blink_nxt;
        end
    end
`endif

    // Next phase, dwell counter and request latch; priority: enable, flash, tick.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = ped_pending | ped_req;
        start_nxt = 1'b0;
        dur       = dur_of(state, G_DUR, Y_DUR, AR_DUR, P_DUR);
`ifdef TLC_FLASH_EN
        blink_nxt = 1'b0;
`endif
        if (!enable) begin
            state_nxt = AR_NS;
            cnt_nxt   = '0;
        end
`ifdef TLC_FLASH_EN
        else if (flash_req) begin
            state_nxt = FLASH;
            cnt_nxt   = '0;
            start_nxt = (state != FLASH);
            blink_nxt = (state == FLASH) ? (blink ^ tick) : 1'b1;
        end else if (state == FLASH) begin
            state_nxt = AR_NS;
            cnt_nxt   = '0;
            start_nxt = 1'b1;
        end
`else
        else if (3'(state) == 3'd7) begin
            state_nxt = AR_NS;
            cnt_nxt   = '0;
        end
`endif
        else if (tick) begin
            if (cnt == dur - CNT_W'(1)) begin
                state_nxt = next_of(state, ped_pending);
                cnt_nxt   = '0;
                start_nxt = 1'b1;
                if (state_nxt == PED) begin
                    pend_nxt = 1'b0;
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Moore lamp decode straight from the phase register.
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        ped_walk = 1'b0;
        case (state)
            NS_G:  ns_light = LAMP_GRN;
            NS_Y:  ns_light = LAMP_YEL;
            EW_G:  ew_light = LAMP_GRN;
            EW_Y:  ew_light = LAMP_YEL;
            PED:   ped_walk = 1'b1;
`ifdef TLC_FLASH_EN
            FLASH: begin
                ns_light = blink ? LAMP_YEL : LAMP_OFF;
                ew_light = blink ? LAMP_RED : LAMP_OFF;
            end
`endif
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl and tlc_tick_pulse.
// Exercises the FLASH phase too when TLC_FLASH_EN is defined.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rstb, tick, enable, ped_req, timer_out, pulse;
    logic       flash_req = 1'b0;
    logic [2:0] ns_light, ew_light, phase;
    logic       ped_walk, ped_pending, phase_start;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .clk(clk), .rstb(rstb), .tick(tick), .enable(enable), .ped_req(ped_req),
`ifdef TLC_FLASH_EN
        .flash_req(flash_req),
`endif
        .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk),
        .ped_pending(ped_pending), .phase(phase), .phase_start(phase_start)
    );

    tlc_tick_pulse tp (.clk(clk), .rstb(rstb), .timer_out(timer_out), .tick(pulse));

    int checks = 0;
    int errors = 0;

    // Reference model: phase code, ticks remaining in it, request latch.
    int dur [7] = '{2, 8, 3, 2, 8, 3, 5};
    int m_phase, m_left;
    bit m_pend, m_start, m_blink, m_tprev, m_pulse;
    int cyc_n = 0, tick_total = 0, t_ar_last = 0, last_cycle_len = -1;

    function automatic logic [2:0] exp_ns(input int p, input bit b);
        case (p)
            1:       return 3'b001;
            2:       return 3'b010;
            7:       return b ? 3'b010 : 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew(input int p, input bit b);
        case (p)
            4:       return 3'b001;
            5:       return 3'b010;
            7:       return b ? 3'b100 : 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = dur[0]; m_pend = 0; m_start = 0;
        m_blink = 0; m_tprev = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit t, input bit pr, input bit en, input bit fr, input bit tg);
        bit np;
        np = m_pend | pr;
        m_start = 0;
        if (!en) begin
            m_phase = 0; m_left = dur[0];
        end else if (fr) begin
            if (m_phase != 7) begin m_phase = 7; m_blink = 1; m_start = 1; end
            else if (t) m_blink = !m_blink;
        end else if (m_phase == 7) begin
            m_phase = 0; m_left = dur[0]; m_start = 1;
        end else if (t) begin
            m_left--;
            if (m_left == 0) begin
                if (m_phase == 5)      m_phase = m_pend ? 6 : 0;
                else if (m_phase == 6) m_phase = 0;
                else                   m_phase = m_phase + 1;
                m_left = dur[m_phase];
                m_start = 1;
                if (m_phase == 6) np = 0;
            end
        end
        m_pend  = np;
        m_pulse = tg ^ m_tprev;
        m_tprev = tg;
    endtask

    task automatic check_all();
        chk("phase",       32'(phase),       32'(m_phase));
        chk("ns_light",    32'(ns_light),    32'(exp_ns(m_phase, m_blink)));
        chk("ew_light",    32'(ew_light),    32'(exp_ew(m_phase, m_blink)));
        chk("ped_walk",    32'(ped_walk),    32'(m_phase == 6));
        chk("ped_pending", 32'(ped_pending), 32'(m_pend));
        chk("phase_start", 32'(phase_start), 32'(m_start));
        chk("tick_pulse",  32'(pulse),       32'(m_pulse));
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic cyc(input bit t, input bit pr, input bit en);
        tick = t; ped_req = pr; enable = en;
        if ($urandom_range(4) == 0) timer_out = ~timer_out;
        @(posedge clk);
        model_step(t, pr, en, flash_req, timer_out);
        cyc_n++;
        if (t && en) tick_total++;
        #1;
        check_all();
        if (phase_start && phase == 3'd0) begin
            last_cycle_len = tick_total - t_ar_last;
            t_ar_last = tick_total;
        end
    endtask

    // Run with a tick every 4 clks until phase_start reports the target phase.
    task automatic run_to(input int target, input bit pr, input string tag);
        bit hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            cyc(cyc_n % 4 == 0, pr, 1'b1);
            hit = phase_start && (phase == 3'(target));
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    int exp_seq [6] = '{1, 2, 3, 4, 5, 0};
    int exp_dw  [6] = '{2, 8, 3, 2, 8, 3};
    int t_ped, t_re, t_prev;

    initial begin
        rstb = 1'b0; tick = 1'b0; enable = 1'b0; ped_req = 1'b0; timer_out = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        rstb = 1'b1;

        // Base rotation: phase order and per-phase dwell in ticks.
        t_prev = 0;
        for (int k = 0; k < 6; k++) begin
            run_to(exp_seq[k], 1'b0, "reach_base_phase");
            chk("base_dwell", 32'(tick_total - t_prev), 32'(exp_dw[k]));
            t_prev = tick_total;
        end
        chk("base_cycle_len", 32'(last_cycle_len), 32'd26);

        // Single-clk request during NS_G gets served after EW_Y.
        run_to(1, 1'b0, "reach_ns_g");
        cyc(cyc_n % 4 == 0, 1'b1, 1'b1);
        chk("ped_latched", 32'(ped_pending), 32'd1);
        run_to(6, 1'b0, "reach_ped");
        chk("ped_clear_on_entry", 32'(ped_pending), 32'd0);
        t_ped = tick_total;
        run_to(0, 1'b0, "ped_to_ar_ns");
        chk("ped_dwell", 32'(tick_total - t_ped), 32'd5);
        chk("ped_cycle_len", 32'(last_cycle_len), 32'd31);

        // Request held across PED entry: cleared on entry, relatched, served again.
        run_to(6, 1'b1, "reach_ped_held");
        chk("held_clear_on_entry", 32'(ped_pending), 32'd0);
        cyc(cyc_n % 4 == 0, 1'b1, 1'b1);
        chk("held_relatch", 32'(ped_pending), 32'd1);
        run_to(0, 1'b0, "held_to_ar_ns");
        run_to(6, 1'b0, "ped_recurs");
        run_to(0, 1'b0, "recur_to_ar_ns");

        // enable low mid EW_G, ticks still running.
        run_to(4, 1'b0, "reach_ew_g");
        repeat (5) cyc(cyc_n % 4 == 0, 1'b0, 1'b1);
        cyc(cyc_n % 4 == 0, 1'b0, 1'b0);
        chk("disable_ar_ns", 32'(phase), 32'd0);
        repeat (19) cyc(cyc_n % 4 == 0, 1'b0, 1'b0);
        t_re = tick_total;
        run_to(1, 1'b0, "reenable_ns_g");
        chk("reenable_dwell", 32'(tick_total - t_re), 32'd2);

        // No ticks for 1000 clks, then async reset between edges.
        repeat (1000) cyc(1'b0, 1'b0, 1'b1);
        #2 rstb = 1'b0;
        #1 model_reset();
        check_all();
        #1 rstb = 1'b1;

        // Randomised traffic: sparse ticks, occasional requests and disables.
        repeat (800) cyc($urandom_range(2) == 0, $urandom_range(15) == 0,
                         $urandom_range(39) != 0);

`ifdef TLC_FLASH_EN
        run_to(2, 1'b0, "reach_ns_y");
        flash_req = 1'b1;
        repeat (12) cyc(cyc_n % 4 == 0, 1'b0, 1'b1);
        chk("flash_phase", 32'(phase), 32'd7);
        flash_req = 1'b0;
        cyc(cyc_n % 4 == 0, 1'b0, 1'b1);
        chk("flash_exit", 32'(phase), 32'd0);
        t_re = tick_total;
        run_to(1, 1'b0, "flash_to_ns_g");
        chk("flash_exit_dwell", 32'(tick_total - t_re), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
